// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use hazard detection between the ID and ID/EX stages.
import pipe_ctrl_pkg::*;

module hazard_detect (
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic                 memread,
    output logic                 hazard
);

    // x0 is hardwired zero, so a load into it never creates a dependency.
    assign hazard = memread && (rd != '0) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with data-memory wait FSM.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
import pipe_ctrl_pkg::*;

module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_ex_rd,
    input  logic                 id_ex_memread,
    input  logic                 ex_branch_taken,
    input  logic                 ex_mem_memreq,
    input  logic                 dmem_ack,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 ex_mem_en,
    output logic                 mem_wb_en,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 mem_wb_flush,
    output logic                 dmem_req
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_events
`endif
);

    state_t state;
    state_t state_next;
    logic   load_use;
    logic   branch_flush;

    hazard_detect u_hazard_detect (
        .rs1     (id_rs1),
        .rs2     (id_rs2),
        .rd      (id_ex_rd),
        .memread (id_ex_memread),
        .hazard  (load_use)
    );

    // Priority: memory stall, then branch squash, then load-use bubble.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        dmem_req     = 1'b0;
        branch_flush = 1'b0;
        state_next   = state;

        if (reset) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
            state_next   = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (ex_mem_memreq) begin
                        pc_en      = 1'b0;
                        if_id_en   = 1'b0;
                        id_ex_en   = 1'b0;
                        ex_mem_en  = 1'b0;
                        mem_wb_en  = 1'b0;
                        dmem_req   = 1'b1;
                        state_next = MEM_WAIT;
                    end else if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        branch_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        state_next = RUN;
                    end else begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        ex_mem_en = 1'b0;
                        mem_wb_en = 1'b0;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state <= state_next;
    end

`ifdef PIPE_PERF_CNT_EN
    // Counters saturate rather than wrap so long runs never read as short ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_en && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (branch_flush && (flush_events != '1)) begin
                flush_events <= flush_events + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; counter checks only with PIPE_PERF_CNT_EN.
module tb_pipeline_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs1, id_rs2, id_ex_rd;
    logic             id_ex_memread, ex_branch_taken, ex_mem_memreq, dmem_ack;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush, mem_wb_flush, dmem_req;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles, flush_events;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Output bundle: {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,mem_wb flushes, dmem_req}
    logic [8:0] outs;
    assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, mem_wb_flush, dmem_req};

    localparam logic [8:0] O_RESET  = 9'b00000_111_0;
    localparam logic [8:0] O_IDLE   = 9'b11111_000_0;
    localparam logic [8:0] O_LDUSE  = 9'b00111_010_0;
    localparam logic [8:0] O_BRANCH = 9'b11111_110_0;
    localparam logic [8:0] O_MEMSTL = 9'b00000_000_1;
    localparam logic [8:0] O_MEMACK = 9'b11111_000_1;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_ex_rd        (id_ex_rd),
        .id_ex_memread   (id_ex_memread),
        .ex_branch_taken (ex_branch_taken),
        .ex_mem_memreq   (ex_mem_memreq),
        .dmem_ack        (dmem_ack),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_flush    (mem_wb_flush),
        .dmem_req        (dmem_req)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Check combinational outputs mid-cycle, then advance past the next rising edge.
    task automatic cyc(input string tag, input logic [8:0] exp);
        @(negedge clk);
        check(tag, 64'(outs), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_ex_rd = 5'd0;
        id_ex_memread = 1'b0; ex_branch_taken = 1'b0;
        ex_mem_memreq = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic check_cnt(input string tag, input int exp_stall, input int exp_flush);
`ifdef PIPE_PERF_CNT_EN
        check({tag, "_stall"}, 64'(stall_cycles), 64'(exp_stall));
        check({tag, "_flush"}, 64'(flush_events), 64'(exp_flush));
`else
        if (tag.len() == 0 && exp_stall != exp_flush) $display("note: empty tag");
`endif
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #1;

        // Reset held two cycles
        cyc("reset_c0", O_RESET);
        cyc("reset_c1", O_RESET);
        check_cnt("reset_cnt", 0, 0);
        reset = 1'b0;
        cyc("run_idle", O_IDLE);

        // Load-use via rs2, then x0 destination, then via rs1
        id_ex_memread = 1'b1; id_ex_rd = 5'd5; id_rs2 = 5'd5;
        cyc("lduse_rs2", O_LDUSE);
        check_cnt("lduse_cnt", 1, 0);
        id_ex_rd = 5'd0; id_rs2 = 5'd0;
        cyc("lduse_x0", O_IDLE);
        id_ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd3;
        cyc("lduse_rs1", O_LDUSE);
        id_ex_memread = 1'b0;
        cyc("no_load", O_IDLE);
        check_cnt("lduse2_cnt", 2, 0);

        // Branch with simultaneous load-use: branch wins
        ex_branch_taken = 1'b1; id_ex_memread = 1'b1; id_ex_rd = 5'd5; id_rs2 = 5'd5;
        cyc("br_lduse", O_BRANCH);
        check_cnt("br_cnt", 2, 1);
        idle_inputs();

        // Memory access acked after 3 stall cycles
        ex_mem_memreq = 1'b1;
        cyc("mem_req", O_MEMSTL);
        cyc("mem_wait1", O_MEMSTL);
        cyc("mem_wait2", O_MEMSTL);
        dmem_ack = 1'b1;
        cyc("mem_ack", O_MEMACK);
        check_cnt("mem_cnt", 5, 1);
        ex_mem_memreq = 1'b0;
        cyc("ack_in_run", O_IDLE);
        dmem_ack = 1'b0;
        cyc("after_ack", O_IDLE);

        // Branch together with memreq: memory stall first, branch flush after ack
        ex_mem_memreq = 1'b1; ex_branch_taken = 1'b1;
        cyc("mem_br_req", O_MEMSTL);
        dmem_ack = 1'b1;
        cyc("mem_br_ack", O_MEMACK);
        ex_mem_memreq = 1'b0; dmem_ack = 1'b0;
        cyc("br_after_ack", O_BRANCH);
        check_cnt("mem_br_cnt", 6, 2);
        idle_inputs();

        // Reset in MEM_WAIT abandons the access
        ex_mem_memreq = 1'b1;
        cyc("rst_mw_req", O_MEMSTL);
        reset = 1'b1;
        cyc("rst_mw_reset", O_RESET);
        check_cnt("rst_mw_cnt", 0, 0);
        reset = 1'b0; ex_mem_memreq = 1'b0; dmem_ack = 1'b1;
        cyc("rst_mw_run", O_IDLE);
        dmem_ack = 1'b0;
        cyc("rst_mw_idle", O_IDLE);
        check_cnt("rst_mw_cnt2", 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
